// File: rtl/fb_pkg.sv
// Shared framebuffer definitions. The scan-out side imports this package too,
// so both sides agree on the frame geometry and on which byte holds each pixel.
package fb_pkg;

  localparam logic [31:0] FB_BASE         = 32'h4000_0000;
  localparam int unsigned H_PIXELS        = 640;
  localparam int unsigned V_LINES         = 480;
  localparam int unsigned WORDS_PER_FRAME = H_PIXELS * V_LINES / 4;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  typedef enum logic {
    BUF_EMPTY,
    BUF_WAIT_ACK
  } buf_state_e;

  // Bit offset of the byte lane for pixel slot 0..3: slot 0 is [31:24].
  function automatic int unsigned lane_lsb(input logic [1:0] slot);
    return {27'd0, ~slot, 3'b000};
  endfunction

endpackage

// File: rtl/framebuffer_writer_packer.sv
// Packs four RGB332 pixels into one 32-bit word in raster order. On realign the
// partial word is dropped and the current pixel restarts at slot 0.
module pixel_packer
  import fb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        accept_i,
  input  logic        realign_i,
  input  logic [7:0]  pix_i,
  output logic [1:0]  pcnt_o,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  pcnt_q, pcnt_d;
  logic [31:0] sr_q, sr_d;
  logic [1:0]  slot;
  logic [31:0] merged;

  always_comb begin
    slot   = realign_i ? 2'd0 : pcnt_q;
    merged = realign_i ? '0 : sr_q;
    merged[lane_lsb(slot) +: 8] = pix_i;

    sr_d         = sr_q;
    pcnt_d       = pcnt_q;
    word_valid_o = 1'b0;
    if (accept_i) begin
      sr_d         = merged;
      // slot 3 wraps the 2-bit counter back to 0 on its own
      pcnt_d       = slot + 2'd1;
      word_valid_o = (slot == 2'd3);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q <= '0;
      sr_q   <= '0;
    end else begin
      pcnt_q <= pcnt_d;
      sr_q   <= sr_d;
    end
  end

  assign pcnt_o = pcnt_q;
  assign word_o = merged;

endmodule

// File: rtl/framebuffer_writer.sv
// Pixel stream to framebuffer word writer: packs RGB332 pixels four per word and
// writes them through a single-entry req/ack buffer with a wrapping frame address.
module framebuffer_writer #(
  parameter logic [31:0] BASE_ADDR = fb_pkg::FB_BASE,
  parameter int unsigned H_PIXELS  = fb_pkg::H_PIXELS,
  parameter int unsigned V_LINES   = fb_pkg::V_LINES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [7:0]  pix_data,
  input  logic        pix_sof,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  output logic        frame_done,
  output logic        sof_err
);

  import fb_pkg::*;

  localparam int unsigned WORDS  = H_PIXELS * V_LINES / 4;
  localparam int unsigned WCNT_W = $clog2(WORDS);
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(WORDS - 1);

  buf_state_e        state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [31:0]       addr_q, wdata_q;
  logic              last_q;
  logic              frame_done_q, sof_err_q;

  logic        accept, realign;
  logic [1:0]  pcnt;
  logic        word_valid;
  logic [31:0] word;
  logic [31:0] word_ofs;

  assign pix_ready = !(pcnt == 2'd3 && state_q == BUF_WAIT_ACK);
  assign accept    = pix_valid && pix_ready;
  assign realign   = accept && pix_sof && !(pcnt == 2'd0 && wcnt_q == '0);

  pixel_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .accept_i     (accept),
    .realign_i    (realign),
    .pix_i        (pix_data),
    .pcnt_o       (pcnt),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      BUF_EMPTY:    if (word_valid) state_d = BUF_WAIT_ACK;
      BUF_WAIT_ACK: if (mem_ack)    state_d = BUF_EMPTY;
      default:      state_d = BUF_EMPTY;
    endcase
  end

  // A realign never coincides with a load, and never touches a pending write.
  always_comb begin
    wcnt_d = wcnt_q;
    if (realign)         wcnt_d = '0;
    else if (word_valid) wcnt_d = (wcnt_q == LAST_WORD) ? '0 : wcnt_q + 1'b1;
  end

  always_comb begin
    word_ofs = '0;
    word_ofs[WCNT_W+1:0] = {wcnt_q, 2'b00};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BUF_EMPTY;
      wcnt_q       <= '0;
      addr_q       <= BASE_ADDR;
      wdata_q      <= '0;
      last_q       <= 1'b0;
      frame_done_q <= 1'b0;
      sof_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      frame_done_q <= (state_q == BUF_WAIT_ACK) && mem_ack && last_q;
      sof_err_q    <= realign;
      if (word_valid) begin
        addr_q  <= BASE_ADDR + word_ofs;
        wdata_q <= word;
        last_q  <= (wcnt_q == LAST_WORD);
      end
    end
  end

  assign mem_req    = (state_q == BUF_WAIT_ACK);
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign frame_done = frame_done_q;
  assign sof_err    = sof_err_q;

endmodule

// File: tb/tb_framebuffer_writer.sv
// Directed bench for framebuffer_writer on a reduced 16x4 frame (16 words).
module tb_framebuffer_writer;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int unsigned NWORDS = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [7:0]  pix_data = '0;
  logic        pix_sof = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic        frame_done;
  logic        sof_err;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  int unsigned cyc = 0;
  int unsigned req_cycles = 0;
  int unsigned acc_cnt = 0;
  int unsigned fd_cnt = 0;
  int unsigned fd_cyc = 0;
  int unsigned se_cnt = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int unsigned wr_cyc[$];

  framebuffer_writer #(
    .BASE_ADDR (BASE),
    .H_PIXELS  (16),
    .V_LINES   (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_data   (pix_data),
    .pix_sof    (pix_sof),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .frame_done (frame_done),
    .sof_err    (sof_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_req) req_cycles <= req_cycles + 1;
    if (pix_valid && pix_ready && rst_n) acc_cnt <= acc_cnt + 1;
    if (mem_req && mem_ack) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
      wr_cyc.push_back(cyc);
    end
    if (frame_done) begin
      fd_cnt <= fd_cnt + 1;
      fd_cyc <= cyc;
    end
    if (sof_err) se_cnt <= se_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic sof);
    int unsigned n;
    pix_valid = 1'b1;
    pix_data  = d;
    pix_sof   = sof;
    n = 0;
    while (!pix_ready && n < 50) begin
      tick();
      n++;
    end
    if (!pix_ready) check("push_timeout", {31'd0, pix_ready}, 32'd1);
    tick();
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  function automatic logic [7:0] pat(input int unsigned i);
    return 8'(i * 37 + 5);
  endfunction

  initial begin
    int unsigned n0, a0, r0;
    logic [31:0] exp_word;

    // Reset and idle
    repeat (3) tick();
    check("rst_ready", {31'd0, pix_ready}, 32'd1);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_addr", mem_addr, BASE);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_fdone", {31'd0, frame_done}, 32'd0);
    check("rst_soferr", {31'd0, sof_err}, 32'd0);
    rst_n = 1'b1;
    repeat (20) tick();
    check("idle_req_cycles", req_cycles, 32'd0);
    check("idle_ready", {31'd0, pix_ready}, 32'd1);

    // One word with ack tied high
    mem_ack = 1'b1;
    r0 = req_cycles;
    push(8'hE0, 1'b1);
    push(8'h1C, 1'b0);
    push(8'h03, 1'b0);
    push(8'hFF, 1'b0);
    repeat (3) tick();
    check("w0_count", wr_addr.size(), 32'd1);
    check("w0_addr", wr_addr[0], BASE);
    check("w0_data", wr_data[0], 32'hE01C03FF);
    check("w0_req_len", req_cycles - r0, 32'd1);
    check("w0_soferr", se_cnt, 32'd0);

    // Stall: 7 pixels accepted, 8th held off until after the ack
    mem_ack = 1'b0;
    a0 = acc_cnt;
    for (int i = 0; i < 7; i++) push(8'(17 * (i + 1)), 1'b0);
    pix_valid = 1'b1;
    pix_data  = 8'h88;
    check("stall_ready0", {31'd0, pix_ready}, 32'd0);
    repeat (6) tick();
    check("stall_ready1", {31'd0, pix_ready}, 32'd0);
    check("stall_accepts", acc_cnt - a0, 32'd7);
    check("stall_req", {31'd0, mem_req}, 32'd1);
    mem_ack = 1'b1;
    check("ack_cycle_ready", {31'd0, pix_ready}, 32'd0);
    tick();
    check("post_ack_ready", {31'd0, pix_ready}, 32'd1);
    tick();
    pix_valid = 1'b0;
    repeat (3) tick();
    check("stall_accepts8", acc_cnt - a0, 32'd8);
    check("stall_count", wr_addr.size(), 32'd3);
    check("stall_w1_addr", wr_addr[1], BASE + 32'h4);
    check("stall_w1_data", wr_data[1], 32'h11223344);
    check("stall_w2_addr", wr_addr[2], BASE + 32'h8);
    check("stall_w2_data", wr_data[2], 32'h55667788);

    // pix_sof on the 3rd pixel of a word
    push(8'hA1, 1'b0);
    push(8'hA2, 1'b0);
    push(8'hB3, 1'b1);
    push(8'hB4, 1'b0);
    push(8'hB5, 1'b0);
    push(8'hB6, 1'b0);
    repeat (3) tick();
    check("sof_err_pulses", se_cnt, 32'd1);
    check("sof_count", wr_addr.size(), 32'd4);
    check("sof_addr", wr_addr[3], BASE);
    check("sof_data", wr_data[3], 32'hB3B4B5B6);
    check("sof_fdone", fd_cnt, 32'd0);

    // Rest of the frame (words 1..15), then a proper frame start
    n0 = wr_addr.size();
    exp_word = '0;
    for (int unsigned i = 4; i < NWORDS * 4; i++) begin
      push(pat(i), 1'b0);
      exp_word = {exp_word[23:0], pat(i)};
    end
    repeat (3) tick();
    check("frame_count", wr_addr.size() - n0, NWORDS - 1);
    check("frame_last_addr", wr_addr[wr_addr.size() - 1], BASE + 32'h3C);
    check("frame_last_data", wr_data[wr_data.size() - 1], exp_word);
    check("frame_done_cnt", fd_cnt, 32'd1);
    check("frame_done_time", fd_cyc, wr_cyc[wr_cyc.size() - 1] + 1);
    push(8'h01, 1'b1);
    push(8'h02, 1'b0);
    push(8'h03, 1'b0);
    push(8'h04, 1'b0);
    repeat (3) tick();
    check("wrap_addr", wr_addr[wr_addr.size() - 1], BASE);
    check("wrap_data", wr_data[wr_data.size() - 1], 32'h01020304);
    check("wrap_soferr", se_cnt, 32'd1);
    check("wrap_fdone", fd_cnt, 32'd1);

    // Reset during a pending write
    mem_ack = 1'b0;
    push(8'hC1, 1'b0);
    push(8'hC2, 1'b0);
    push(8'hC3, 1'b0);
    push(8'hC4, 1'b0);
    tick();
    check("pre_rst_req", {31'd0, mem_req}, 32'd1);
    n0 = wr_addr.size();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_req", {31'd0, mem_req}, 32'd0);
    tick();
    rst_n = 1'b1;
    mem_ack = 1'b1;
    tick();
    push(8'hD1, 1'b0);
    push(8'hD2, 1'b0);
    push(8'hD3, 1'b0);
    push(8'hD4, 1'b0);
    repeat (3) tick();
    check("post_rst_count", wr_addr.size() - n0, 32'd1);
    check("post_rst_addr", wr_addr[wr_addr.size() - 1], BASE);
    check("post_rst_data", wr_data[wr_data.size() - 1], 32'hD1D2D3D4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/framebuffer_writer.md
# framebuffer_writer

Write-side counterpart of the VGA scan-out path. Accepts a raster-ordered stream of RGB332 pixels over a valid/ready handshake, packs four pixels per 32-bit word in the same byte order the scan-out reads, and issues word writes to framebuffer memory through a req/ack handshake. The address advances by 4 per word and wraps to the frame base after one full frame. Sits between any pixel producer (renderer, sprite engine, test pattern) and the memory shared with the VGA controller.

## Interface
- BASE_ADDR, 32'h4000_0000, byte address of frame word 0
- H_PIXELS, 640, pixels per line
- V_LINES, 480, lines per frame
- clock  in  1  single clock domain
- reset  in  1  asynchronous, active-low
- pix_valid  in  1  pixel present on pix_data
- pix_ready  out  1  block accepts pixel this cycle
- pix_data  in  8  RGB332: r=[7:5], g=[4:2], b=[1:0]
- pix_sof  in  1  qualifies first pixel of a frame (sampled with pix_valid)
- mem_req  out  1  write request, held until mem_ack
- mem_addr  out  32  word-aligned byte address
- mem_wdata  out  32  packed word
- mem_ack  in  1  memory accepted the write this cycle
- frame_done  out  1  one-cycle pulse after the last word of a frame is acked
- sof_err  out  1  one-cycle pulse when pix_sof arrives off a frame boundary

## Operation
- Pixel accepted when pix_valid && pix_ready.
- Pack position pcnt, 0..3: pixel 0 goes to [31:24], 1 to [23:16], 2 to [15:8], 3 to [7:0].
- On acceptance at pcnt=3, the completed word and its address move into the write buffer. pcnt returns to 0.
- Write buffer FSM:
  - EMPTY: mem_req=0.
  - WAIT_ACK: mem_req=1, mem_addr and mem_wdata stable.
  - EMPTY -> WAIT_ACK on load.
  - WAIT_ACK -> EMPTY on mem_ack.
  - mem_ack is ignored in EMPTY.
- pix_ready = !(pcnt==3 && buffer in WAIT_ACK). There is no combinational path from mem_ack.
- Word counter wcnt runs 0..WORDS-1, where WORDS = H_PIXELS*V_LINES/4 = 76800 (17 bits).
  - Address of a loaded word = BASE_ADDR + 4*wcnt.
  - wcnt increments on each load.
  - After wcnt = WORDS-1, wcnt wraps to 0.
- frame_done pulses the cycle after mem_ack of the word loaded with wcnt = WORDS-1.
- pix_sof handling:
  - pix_sof on an accepted pixel with pcnt=0 and wcnt=0: normal frame start, no error.
  - Otherwise the block realigns:
    - The partial pack is discarded.
    - wcnt and pcnt reset, and the sof pixel becomes pixel 0 of word 0 at BASE_ADDR.
    - sof_err pulses one cycle.
    - A write already in WAIT_ACK completes at its original address.
- A pix_sof-accepting pixel that also completes a word cannot occur; the realign applies first.

## Timing
- Reset values: pix_ready=1, mem_req=0, mem_addr=BASE_ADDR, mem_wdata=0, frame_done=0, sof_err=0, pcnt=0, wcnt=0.
- Reset asserting mid-write drops mem_req immediately (asynchronous); the pending word is lost.
- Latency: 4th pixel accepted in cycle N -> mem_req=1 in cycle N+1.
- A mem_ack in the same cycle as mem_req rises is legal; the buffer is EMPTY in the next cycle.
- Sustained throughput with mem_ack held high: one pixel per clock, one write per 4 clocks.
- Under mem_ack stall: 3 further pixels are accepted, then pix_ready=0 until the cycle after mem_ack.
- sof_err and frame_done are registered, each high for exactly one cycle.

## Structure
- Shared package fb_pkg holds:
  - FB_BASE, H_PIXELS, V_LINES, WORDS_PER_FRAME
  - rgb332_t typedef
  - byte-lane index function for pixel slot 0..3
- The scan-out side imports the same package so byte order cannot diverge.
- Sub-module pixel_packer (pcnt, shift/insert, discard on realign, word_valid out).
- Top level keeps the write-buffer FSM and the address counter.

## Test plan
- Reset -> all outputs at reset values, pix_ready=1, no mem_req for 20 idle cycles.
- Pixels E0,1C,03,FF (sof on first), mem_ack tied 1 -> one write, addr 0x4000_0000, wdata 0xE01C03FF, mem_req high exactly one cycle.
- mem_ack held 0 for 10 cycles, 8 pixels offered back-to-back:
  - 7 accepted, then pix_ready=0.
  - After ack, the 8th is accepted.
  - Second write goes to 0x4000_0004.
- Full frame of 307200 pixels, mem_ack=1:
  - Last write at 0x4004_AFFC.
  - frame_done pulses once.
  - The next word goes to 0x4000_0000.
- pix_sof on the 3rd pixel of a word -> sof_err one-cycle pulse, two partial pixels never written, next write at 0x4000_0000 starting with the sof pixel.
- Reset asserted while mem_req=1 -> mem_req=0 in the same cycle; after release, the first write goes to 0x4000_0000.
